ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/kbd_fifo.sv | 97 +++++++++
 rtl/ps2_scancode_decoder.sv | 190 +++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 scan-code decoder slice.
//   - Scan-code constants for the prefix bytes and the modifier keys.
//   - The prefix-tracking FSM state encoding.
// No ports; imported by ps2_scancode_decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // IDLE    : no prefix pending, next byte is a make code or a prefix
    // EXT     : E0 seen, next byte is an extended make code or F0
    // BRK     : F0 seen, next byte is the key being released
    // EXT_BRK : E0 F0 seen, next byte is an extended key being released
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo
// Show-ahead FIFO with a sticky overflow flag.
// Parameters:
//   DEPTH : number of entries, power of 2 (2..32)
//   WIDTH : entry width in bits
// Ports:
//   clk      in  : clock
//   rst      in  : synchronous active-high reset
//   push     in  : write wr_data this edge
//   pop      in  : discard the head entry this edge (ignored when empty)
//   ovf_clr  in  : clear the sticky overflow flag
//   wr_data  in  : data to write
//   rd_data  out : head entry, zero while empty
//   empty    out : no entries held
//   full     out : DEPTH entries held
//   overflow out : sticky, set when a push is dropped
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             ovf_clr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_pop, do_push, drop;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a
    // push when it is also being read. Pointers wrap naturally because the
    // depth is a power of two.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != FULL_COUNT) || do_pop);
        drop    = push && !do_push;

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end

        // A drop on the same edge as a clear must leave the flag set
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign overflow = overflow_q;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns PS/2 set-2 scan-code bytes into ASCII characters queued in a FIFO
// for the CPU, tracking shift and caps-lock state along the way.
// Parameters:
//   FIFO_DEPTH : ASCII entries buffered, power of 2 (2..32)
// Ports:
//   clk        in  : system clock
//   rst        in  : synchronous active-high reset
//   code_in    in  : scan-code byte from the PS/2 receiver
//   code_valid in  : receiver ready level; only its rising edge is used
//   rd_en      in  : pop request from the CPU bus
//   ovf_clr    in  : clears the overflow flag
//   key_data   out : ASCII code at the FIFO head
//   empty      out : FIFO holds no entries
//   full       out : FIFO holds FIFO_DEPTH entries
//   overflow   out : sticky, set when a character is dropped
//   mods       out : {caps_lock, shift}
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       rd_en,
    input  logic       ovf_clr,
    output logic [7:0] key_data,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic [1:0] mods
);

    ps2_state_e state_q, state_d;
    logic       code_valid_d_q;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_q, caps_d;
    logic       accept;
    logic       push;
    logic [7:0] ascii_lower;
    logic [7:0] ascii;
    logic       is_letter;
    logic       upper;

    // Scan-code to ASCII table. Letters are listed in lowercase; the case
    // adjustment is applied afterwards so digits and controls never shift.
    always_comb begin
        ascii_lower = 8'h00;
        case (code_in)
            8'h1C: ascii_lower = 8'h61;
            8'h32: ascii_lower = 8'h62;
            8'h21: ascii_lower = 8'h63;
            8'h23: ascii_lower = 8'h64;
            8'h24: ascii_lower = 8'h65;
            8'h2B: ascii_lower = 8'h66;
            8'h34: ascii_lower = 8'h67;
            8'h33: ascii_lower = 8'h68;
            8'h43: ascii_lower = 8'h69;
            8'h3B: ascii_lower = 8'h6A;
            8'h42: ascii_lower = 8'h6B;
            8'h4B: ascii_lower = 8'h6C;
            8'h3A: ascii_lower = 8'h6D;
            8'h31: ascii_lower = 8'h6E;
            8'h44: ascii_lower = 8'h6F;
            8'h4D: ascii_lower = 8'h70;
            8'h15: ascii_lower = 8'h71;
            8'h2D: ascii_lower = 8'h72;
            8'h1B: ascii_lower = 8'h73;
            8'h2C: ascii_lower = 8'h74;
            8'h3C: ascii_lower = 8'h75;
            8'h2A: ascii_lower = 8'h76;
            8'h1D: ascii_lower = 8'h77;
            8'h22: ascii_lower = 8'h78;
            8'h35: ascii_lower = 8'h79;
            8'h1A: ascii_lower = 8'h7A;
            8'h45: ascii_lower = 8'h30;
            8'h16: ascii_lower = 8'h31;
            8'h1E: ascii_lower = 8'h32;
            8'h26: ascii_lower = 8'h33;
            8'h25: ascii_lower = 8'h34;
            8'h2E: ascii_lower = 8'h35;
            8'h36: ascii_lower = 8'h36;
            8'h3D: ascii_lower = 8'h37;
            8'h3E: ascii_lower = 8'h38;
            8'h46: ascii_lower = 8'h39;
            8'h29: ascii_lower = 8'h20;
            8'h5A: ascii_lower = 8'h0D;
            8'h66: ascii_lower = 8'h08;
            8'h0D: ascii_lower = 8'h09;
            default: ascii_lower = 8'h00;
        endcase
    end

    // Caps lock inverts the effect of shift for letters only
    always_comb begin
        is_letter = (ascii_lower >= 8'h61) && (ascii_lower <= 8'h7A);
        upper     = (lshift_q || rshift_q) ^ caps_q;
        ascii     = (is_letter && upper) ? (ascii_lower - 8'h20) : ascii_lower;
    end

    // Prefix FSM and modifier tracking. Nothing moves except on the rising
    // edge of code_valid, so a receiver holding its ready level for many
    // cycles still yields one byte. Extended keys are ignored entirely.
    always_comb begin
        accept   = code_valid && !code_valid_d_q;
        state_d  = state_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        push     = 1'b0;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (code_in == SC_EXT) begin
                        state_d = EXT;
                    end else if (code_in == SC_BRK) begin
                        state_d = BRK;
                    end else if (code_in == SC_LSHIFT) begin
                        lshift_d = 1'b1;
                    end else if (code_in == SC_RSHIFT) begin
                        rshift_d = 1'b1;
                    end else if (code_in == SC_CAPS) begin
                        caps_d = !caps_q;
                    end else begin
                        push = (ascii != 8'h00);
                    end
                end
                EXT: begin
                    state_d = (code_in == SC_BRK) ? EXT_BRK : IDLE;
                end
                BRK: begin
                    // Releasing caps lock does nothing; it toggles on press
                    if (code_in == SC_LSHIFT) begin
                        lshift_d = 1'b0;
                    end else if (code_in == SC_RSHIFT) begin
                        rshift_d = 1'b0;
                    end
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // code_valid_d resets high so a level still asserted when reset lifts
    // is not mistaken for a fresh byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            code_valid_d_q <= 1'b1;
            lshift_q       <= 1'b0;
            rshift_q       <= 1'b0;
            caps_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_valid_d_q <= code_valid;
            lshift_q       <= lshift_d;
            rshift_q       <= rshift_d;
            caps_q         <= caps_d;
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (rd_en),
        .ovf_clr  (ovf_clr),
        .wr_data  (ascii),
        .rd_data  (key_data),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    assign mods = {caps_q, lshift_q || rshift_q};

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
// Self-checking bench for ps2_scancode_decoder: a table of single-key
// vectors, hand-written multi-byte sequences and a randomized run compared
// against a queue-based reference model of the keyboard decoder.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic [7:0] code_in;
    logic       code_valid;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] key_data;
    logic       empty;
    logic       full;
    logic       overflow;
    logic [1:0] mods;

    int errors = 0;
    int checks = 0;

    ps2_scancode_decoder #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .rd_en      (rd_en),
        .ovf_clr    (ovf_clr),
        .key_data   (key_data),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .mods       (mods)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of characters plus keyboard state
    logic [7:0] mq[$];
    bit         m_lsh, m_rsh, m_caps, m_ovf;
    bit         m_after_e0, m_after_f0;
    bit         m_prev_cv = 1'b1;

    logic [7:0] letter_codes [26];
    logic [7:0] digit_codes  [10];

    // Character a key produces, derived from the keyboard layout tables
    function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit upper);
        ref_ascii = 8'h00;
        for (int i = 0; i < 26; i++) begin
            if (letter_codes[i] == code) begin
                ref_ascii = upper ? 8'(65 + i) : 8'(97 + i);
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (digit_codes[i] == code) begin
                ref_ascii = 8'(48 + i);
            end
        end
        if (code == 8'h29) ref_ascii = 8'h20;
        if (code == 8'h5A) ref_ascii = 8'h0D;
        if (code == 8'h66) ref_ascii = 8'h08;
        if (code == 8'h0D) ref_ascii = 8'h09;
    endfunction

    // Advance the model by one clock edge with the inputs seen on that edge
    task automatic model_step(input logic r, input logic [7:0] c, input logic v,
                              input logic rd, input logic clr);
        bit         acc;
        bit         want_push;
        bit         drop;
        logic [7:0] ch;
        if (r) begin
            mq.delete();
            m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0;
            m_after_e0 = 0; m_after_f0 = 0;
            m_prev_cv = 1'b1;
            return;
        end
        acc       = v && !m_prev_cv;
        want_push = 0;
        ch        = 8'h00;
        if (acc) begin
            if (m_after_e0) begin
                if (c == 8'hF0 && !m_after_f0) begin
                    m_after_f0 = 1;
                end else begin
                    m_after_e0 = 0;
                    m_after_f0 = 0;
                end
            end else if (m_after_f0) begin
                if (c == 8'h12) m_lsh = 0;
                if (c == 8'h59) m_rsh = 0;
                m_after_f0 = 0;
            end else begin
                if (c == 8'hE0) m_after_e0 = 1;
                else if (c == 8'hF0) m_after_f0 = 1;
                else if (c == 8'h12) m_lsh = 1;
                else if (c == 8'h59) m_rsh = 1;
                else if (c == 8'h58) m_caps = !m_caps;
                else begin
                    ch = ref_ascii(c, (m_lsh || m_rsh) != m_caps);
                    want_push = (ch != 8'h00);
                end
            end
        end
        if (rd && mq.size() > 0) void'(mq.pop_front());
        drop = 0;
        if (want_push) begin
            if (mq.size() < DEPTH) mq.push_back(ch);
            else drop = 1;
        end
        if (clr) m_ovf = 0;
        if (drop) m_ovf = 1;
        m_prev_cv = v;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle from a negedge, update the model on the posedge and
    // return on the following negedge where outputs are sampled.
    task automatic applyStimulus(input logic r, input logic [7:0] c, input logic v,
                                 input logic rd, input logic clr);
        rst = r; code_in = c; code_valid = v; rd_en = rd; ovf_clr = clr;
        @(posedge clk);
        model_step(r, c, v, rd, clr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] c, input logic rd, input logic clr);
        applyStimulus(1'b0, c, 1'b1, rd, clr);
        applyStimulus(1'b0, c, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_model(input string tag);
        checkOutput({tag, ".key_data"}, int'(key_data), (mq.size() > 0) ? int'(mq[0]) : 0);
        checkOutput({tag, ".empty"},    int'(empty),    int'(mq.size() == 0));
        checkOutput({tag, ".full"},     int'(full),     int'(mq.size() == DEPTH));
        checkOutput({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        checkOutput({tag, ".mods"},     int'(mods),     int'({m_caps, m_lsh || m_rsh}));
    endtask

    typedef struct {
        logic [7:0] code;
        logic [7:0] plain;
        logic [7:0] shifted;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] pool [16];
    logic [7:0] fill_codes [11];
    logic [7:0] drain_exp [8];

    initial begin
        letter_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                         8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                         8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        digit_codes  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

        vecs[0]  = '{8'h1C, 8'h61, 8'h41};
        vecs[1]  = '{8'h1A, 8'h7A, 8'h5A};
        vecs[2]  = '{8'h32, 8'h62, 8'h42};
        vecs[3]  = '{8'h4D, 8'h70, 8'h50};
        vecs[4]  = '{8'h45, 8'h30, 8'h30};
        vecs[5]  = '{8'h16, 8'h31, 8'h31};
        vecs[6]  = '{8'h46, 8'h39, 8'h39};
        vecs[7]  = '{8'h29, 8'h20, 8'h20};
        vecs[8]  = '{8'h5A, 8'h0D, 8'h0D};
        vecs[9]  = '{8'h66, 8'h08, 8'h08};
        vecs[10] = '{8'h0D, 8'h09, 8'h09};
        vecs[11] = '{8'h76, 8'h00, 8'h00};
        vecs[12] = '{8'h05, 8'h00, 8'h00};

        pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h1A, 8'h45,
                 8'h29, 8'h5A, 8'h75, 8'h00, 8'h0D, 8'h66, 8'h32, 8'h4D};

        // a..h fill the FIFO, i is dropped, k and l go in with a read
        fill_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                       8'h43, 8'h42, 8'h4B};
        drain_exp  = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6B, 8'h6C};

        rst = 1'b1; code_in = 8'h00; code_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;

        // Reset state
        do_reset();
        checkOutput("reset.key_data", int'(key_data), 8'h00);
        checkOutput("reset.empty",    int'(empty),    1);
        checkOutput("reset.full",     int'(full),     0);
        checkOutput("reset.overflow", int'(overflow), 0);
        checkOutput("reset.mods",     int'(mods),     0);

        // Single-key table, unshifted then with left shift held
        for (int i = 0; i < 13; i++) begin
            do_reset();
            send_byte(vecs[i].code, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].plain == 8'h00));
            checkOutput($sformatf("vec%0d.key", i), int'(key_data), int'(vecs[i].plain));
            if (vecs[i].plain != 8'h00) pop_one();
            send_byte(8'h12, 1'b0, 1'b0);
            send_byte(vecs[i].code, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d.shift_key", i), int'(key_data), int'(vecs[i].shifted));
            checkOutput($sformatf("vec%0d.shift_mods", i), int'(mods), 1);
        end

        // Long code_valid level gives one character
        do_reset();
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 8'h1C, 1'b1, 1'b0, 1'b0);
        checkOutput("hold.key_data", int'(key_data), 8'h61);
        checkOutput("hold.empty",    int'(empty),    0);
        applyStimulus(1'b0, 8'h1C, 1'b1, 1'b1, 1'b0);
        checkOutput("hold.single_push", int'(empty), 1);
        applyStimulus(1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);

        // Shift press and release
        do_reset();
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b0);
        checkOutput("shift.first",  int'(key_data), 8'h41);
        pop_one();
        checkOutput("shift.second", int'(key_data), 8'h61);
        checkOutput("shift.mods",   int'(mods),     0);
        pop_one();
        checkOutput("shift.drained", int'(empty), 1);

        // Caps lock toggles on press only
        do_reset();
        send_byte(8'h58, 1'b0, 1'b0);
        checkOutput("caps.on", int'(mods), 2);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h58, 1'b0, 1'b0);
        checkOutput("caps.break_no_effect", int'(mods), 2);
        send_byte(8'h1C, 1'b0, 1'b0);
        send_byte(8'h58, 1'b0, 1'b0);
        checkOutput("caps.off", int'(mods), 0);
        send_byte(8'h1C, 1'b0, 1'b0);
        checkOutput("caps.first", int'(key_data), 8'h41);
        pop_one();
        checkOutput("caps.second", int'(key_data), 8'h61);

        // Extended and break sequences push nothing, FSM ends in IDLE
        do_reset();
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0, 1'b0);
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b0);
        checkOutput("ext.no_push", int'(empty), 1);
        send_byte(8'h1C, 1'b0, 1'b0);
        checkOutput("ext.idle_after", int'(key_data), 8'h61);

        // Typematic repeat pushes each time
        send_byte(8'h1C, 1'b0, 1'b0);
        pop_one();
        checkOutput("repeat.second", int'(key_data), 8'h61);

        // Overflow, simultaneous push/pop when full, clear, set-wins
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_byte(fill_codes[i], 1'b0, 1'b0);
        checkOutput("fill.full",     int'(full),     1);
        checkOutput("fill.overflow", int'(overflow), 0);
        send_byte(fill_codes[8], 1'b0, 1'b0);
        checkOutput("drop.full",     int'(full),     1);
        checkOutput("drop.overflow", int'(overflow), 1);
        checkOutput("drop.head",     int'(key_data), 8'h61);
        send_byte(fill_codes[9], 1'b1, 1'b0);
        checkOutput("pushpop.full", int'(full),     1);
        checkOutput("pushpop.head", int'(key_data), 8'h62);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("clr.overflow", int'(overflow), 0);
        send_byte(fill_codes[10], 1'b1, 1'b0);
        checkOutput("pushpop2.overflow", int'(overflow), 0);
        checkOutput("pushpop2.full",     int'(full),     1);
        send_byte(8'h1A, 1'b0, 1'b1);
        checkOutput("setwins.overflow", int'(overflow), 1);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("drain%0d", i), int'(key_data), int'(drain_exp[i]));
            pop_one();
        end
        checkOutput("drain.empty", int'(empty), 1);
        pop_one();
        checkOutput("pop_empty.ignored", int'(empty), 1);
        send_byte(8'h1C, 1'b1, 1'b0);
        checkOutput("push_pop_empty", int'(key_data), 8'h61);

        // Reset mid-sequence abandons the prefix
        do_reset();
        send_byte(8'hE0, 1'b0, 1'b0);
        do_reset();
        send_byte(8'h1C, 1'b0, 1'b0);
        checkOutput("rst_mid.key_data", int'(key_data), 8'h61);

        // code_valid high through reset release is not an accept
        applyStimulus(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h1C, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_level.no_accept", int'(empty), 1);
        applyStimulus(1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] c;
            logic       r;
            c = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                            : pool[$urandom_range(0, 15)];
            r = ($urandom_range(0, 499) == 0);
            applyStimulus(r, c, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            check_model($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
